// File: rtl/cpu_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state encoding
// and default values for the no-op instruction and the sequential PC step.
package cpu_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h6000;
  localparam int          PC_STEP_DEFAULT   = 2;

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; the head word is held in an output
// register that already reflects this cycle's push/pop, so it is valid with count.
module cpu_fetch_fifo
  import cpu_fetch_unit_pkg::*;
#(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_after;
  logic [CW-1:0] count_after_pop;
  logic          do_push, do_pop;

  assign empty           = (count == '0);
  assign full            = (count == DEPTH_C);
  assign do_pop          = pop && !empty;
  assign do_push         = push && (!full || do_pop);
  assign rd_ptr_after    = rd_ptr + AW'(do_pop);
  assign count_after_pop = count - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_after;
      count  <= count_after_pop + CW'(do_push);
      // A word pushed into a FIFO that is empty after this pop becomes the new head
      if (do_push && count_after_pop == '0) rd_data <= wr_data;
      else                                  rd_data <= mem[rd_ptr_after];
    end
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch front end: single-outstanding stb/ack fetch FSM, prefetch FIFO,
// redirect with flush/discard. Optional combinational bypass under FETCH_BYPASS_EN.
module cpu_fetch_unit
  import cpu_fetch_unit_pkg::*;
#(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter int                 DEPTH     = 4,
  parameter int                 PC_STEP   = PC_STEP_DEFAULT,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [INSTR_W-1:0] instr_data_i,
  input  logic               instr_ack_i,
  output logic [ADDR_W-1:0]  instr_addr_o,
  output logic               instr_stb_o,
  output logic               instr_we_o,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic               dec_ready_i,
  output logic               dec_valid_o,
  output logic [INSTR_W-1:0] dec_instr_o,
  output logic [ADDR_W-1:0]  dec_pc_o
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t                state;
  logic                        stb_reg;
  logic [ADDR_W-1:0]           fetch_pc, addr_reg, pc_inc;
  logic [ADDR_W+INSTR_W-1:0]   head;
  logic [CW-1:0]               fifo_count, count_next;
  logic                        fifo_full, fifo_empty, fifo_valid;
  logic                        ack_req, bypass_hit, push, pop, slot_free_after;

  assign fifo_valid = !fifo_empty;
  assign ack_req    = (state == ST_REQ) && instr_ack_i;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = ack_req && !redirect_i && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // Redirect wins over both ends of the FIFO; a bypassed word taken by decode is never stored
  assign pop             = fifo_valid && dec_ready_i && !redirect_i;
  assign push            = ack_req && !redirect_i && !(bypass_hit && dec_ready_i);
  assign count_next      = fifo_count + CW'(push) - CW'(pop);
  assign slot_free_after = (count_next < DEPTH_C);
  assign pc_inc          = fetch_pc + ADDR_W'(PC_STEP);

  assign instr_addr_o = addr_reg;
  assign instr_stb_o  = stb_reg;
  assign instr_we_o   = 1'b0;
  assign dec_valid_o  = fifo_valid || bypass_hit;
  assign dec_instr_o  = bypass_hit ? instr_data_i :
                        fifo_valid ? head[ADDR_W +: INSTR_W] : NOP_INSTR;
  assign dec_pc_o     = bypass_hit ? fetch_pc :
                        fifo_valid ? head[ADDR_W-1:0] : '0;

  cpu_fetch_fifo #(
    .W     (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_i),
    .wr_data ({instr_data_i, fetch_pc}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      stb_reg  <= 1'b0;
      fetch_pc <= RESET_PC;
      addr_reg <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      stb_reg  <= 1'b1;
      // An unacknowledged request must complete at its old address before the target is issued
      if (state != ST_IDLE && !instr_ack_i) begin
        state <= ST_DISCARD;
      end else begin
        state    <= ST_REQ;
        addr_reg <= redirect_pc_i;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_full || pop) begin
            state   <= ST_REQ;
            stb_reg <= 1'b1;
          end
        end
        ST_REQ: begin
          if (instr_ack_i) begin
            fetch_pc <= pc_inc;
            addr_reg <= pc_inc;
            if (!slot_free_after) begin
              state   <= ST_IDLE;
              stb_reg <= 1'b0;
            end
          end
        end
        ST_DISCARD: begin
          if (instr_ack_i) begin
            state    <= ST_REQ;
            addr_reg <= fetch_pc;
          end
        end
        default: begin
          state   <= ST_IDLE;
          stb_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
